// File: rtl/spw_pll_reset_ctrl_pkg.sv
// Shared definitions for the SpaceWire PLL reset sequencer: state codes,
// the registered output bundle and small helpers used by the FSM.
package spw_pll_reset_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_RST_PLL   = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [STATE_W-1:0] ST_STABLE    = 3'd2;
    localparam logic [STATE_W-1:0] ST_RUN       = 3'd3;
    localparam logic [STATE_W-1:0] ST_FAIL      = 3'd4;

    typedef struct packed {
        logic pll_rst;
        logic spw_rst_n;
        logic ready;
        logic fail;
    } ctrl_out_t;

    // Output levels are a pure decode of the state they are registered with.
    function automatic ctrl_out_t decode_outputs(input logic [STATE_W-1:0] st);
        ctrl_out_t o;
        o.pll_rst   = 1'b0;
        o.spw_rst_n = 1'b0;
        o.ready     = 1'b0;
        o.fail      = 1'b0;
        case (st)
            ST_RST_PLL: o.pll_rst = 1'b1;
            ST_RUN: begin
                o.spw_rst_n = 1'b1;
                o.ready     = 1'b1;
            end
            ST_FAIL: begin
                o.pll_rst = 1'b1;
                o.fail    = 1'b1;
            end
            default: o.pll_rst = 1'b0;
        endcase
        return o;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spw_sync_2ff.sv
// Two-flop level synchroniser, 1 bit wide, synchronous active-low reset to 0.
module spw_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spw_pll_reset_ctrl.sv
// SpaceWire PLL reset sequencer: pulses the PLL reset, waits for lock with a
// retry limit, debounces lock, and only then releases the SpaceWire core reset.
module spw_pll_reset_ctrl
    import spw_pll_reset_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 16
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               soft_reset_req,
    output logic               pll_rst,
    output logic               spw_rst_n,
    output logic               ready,
    output logic               fail,
    output logic [STATE_W-1:0] state,
    output logic [7:0]         lock_loss_cnt
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    logic               locked_s;
    logic [STATE_W-1:0] state_next;
    logic [CNT_W-1:0]   counter;
    logic [CNT_W-1:0]   counter_next;
    logic [7:0]         retry_cnt;
    logic [7:0]         retry_next;
    logic [7:0]         loss_next;
    ctrl_out_t          out_next;

    spw_sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // Soft reset overrides every state decision, including a same-cycle lock
    // loss in RUN, so that loss is deliberately not counted.
    always_comb begin
        state_next = state;
        retry_next = retry_cnt;
        loss_next  = lock_loss_cnt;
        if (soft_reset_req) begin
            state_next = ST_RST_PLL;
            retry_next = '0;
        end else begin
            case (state)
                ST_RST_PLL: begin
                    if (counter == RST_LAST) begin
                        state_next = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_next = ST_STABLE;
                    end else if (counter == TIMEOUT_LAST) begin
                        retry_next = retry_cnt + 8'd1;
                        state_next = (retry_next == RETRY_LIMIT) ? ST_FAIL : ST_RST_PLL;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_next = ST_WAIT_LOCK;
                    end else if (counter == STABLE_LAST) begin
                        state_next = ST_RUN;
                        retry_next = '0;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_next = ST_RST_PLL;
                        loss_next  = sat_inc8(lock_loss_cnt);
                    end
                end
                ST_FAIL: state_next = ST_FAIL;
                default: state_next = ST_RST_PLL;
            endcase
        end
    end

    always_comb begin
        if (soft_reset_req || (state_next != state)) begin
            counter_next = '0;
        end else begin
            counter_next = counter + CNT_W'(1);
        end
        out_next = decode_outputs(state_next);
    end

    // Outputs are registered from the next-state decode, so spw_rst_n drops on
    // the very edge that leaves RUN.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state         <= ST_RST_PLL;
            counter       <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            pll_rst       <= 1'b1;
            spw_rst_n     <= 1'b0;
            ready         <= 1'b0;
            fail          <= 1'b0;
        end else begin
            state         <= state_next;
            counter       <= counter_next;
            retry_cnt     <= retry_next;
            lock_loss_cnt <= loss_next;
            pll_rst       <= out_next.pll_rst;
            spw_rst_n     <= out_next.spw_rst_n;
            ready         <= out_next.ready;
            fail          <= out_next.fail;
        end
    end

endmodule

// File: tb/tb_spw_pll_reset_ctrl.sv
// Bench for spw_pll_reset_ctrl: directed sequences plus random lock traffic,
// every cycle compared against a phase/duration model of the sequencer.
module tb_spw_pll_reset_ctrl;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_reset_req;
    logic       pll_rst;
    logic       spw_rst_n;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    logic [7:0] lock_loss_cnt;

    int tests;
    int fails;

    spw_pll_reset_ctrl #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .CNT_W         (16)
    ) dut (
        .refclk         (refclk),
        .rst_n          (rst_n),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .pll_rst        (pll_rst),
        .spw_rst_n      (spw_rst_n),
        .ready          (ready),
        .fail           (fail),
        .state          (state),
        .lock_loss_cnt  (lock_loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef enum int {M_RST, M_WAIT, M_STABLE, M_RUN, M_FAIL} phase_t;

    phase_t m_phase;
    int     m_age;
    int     m_retries;
    int     m_losses;
    bit     sync_pipe[$];

    function automatic logic [2:0] code_of(phase_t p);
        case (p)
            M_RST:    return 3'd0;
            M_WAIT:   return 3'd1;
            M_STABLE: return 3'd2;
            M_RUN:    return 3'd3;
            default:  return 3'd4;
        endcase
    endfunction

    // Phase model: each phase has a duration limit counted in completed cycles;
    // lock is seen through a two-deep history of pll_locked samples.
    task automatic model_edge(input bit l, input bit s, input bit r);
        bit     ls;
        int     done;
        phase_t nxt;
        if (!r) begin
            m_phase   = M_RST;
            m_age     = 0;
            m_retries = 0;
            m_losses  = 0;
            sync_pipe = {1'b0, 1'b0};
            return;
        end
        ls = sync_pipe.pop_front();
        sync_pipe.push_back(l);
        if (s) begin
            m_phase   = M_RST;
            m_age     = 0;
            m_retries = 0;
            return;
        end
        done = m_age + 1;
        nxt  = m_phase;
        case (m_phase)
            M_RST: if (done >= RST_CYCLES) nxt = M_WAIT;
            M_WAIT: begin
                if (ls) nxt = M_STABLE;
                else if (done >= LOCK_TIMEOUT) begin
                    m_retries++;
                    nxt = (m_retries >= MAX_RETRIES) ? M_FAIL : M_RST;
                end
            end
            M_STABLE: begin
                if (!ls) nxt = M_WAIT;
                else if (done >= STABLE_CYCLES) begin
                    nxt       = M_RUN;
                    m_retries = 0;
                end
            end
            M_RUN: begin
                if (!ls) begin
                    m_losses = (m_losses < 255) ? m_losses + 1 : 255;
                    nxt      = M_RST;
                end
            end
            default: nxt = M_FAIL;
        endcase
        m_age   = (nxt == m_phase) ? done : 0;
        m_phase = nxt;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".state"}, 8'(state), 8'(code_of(m_phase)));
        check({tag, ".pll_rst"}, 8'(pll_rst), 8'((m_phase == M_RST) || (m_phase == M_FAIL)));
        check({tag, ".spw_rst_n"}, 8'(spw_rst_n), 8'(m_phase == M_RUN));
        check({tag, ".ready"}, 8'(ready), 8'(m_phase == M_RUN));
        check({tag, ".fail"}, 8'(fail), 8'(m_phase == M_FAIL));
        check({tag, ".loss"}, lock_loss_cnt, 8'(m_losses));
    endtask

    task automatic applyStimulus(input bit l, input bit s, input bit r);
        pll_locked     = l;
        soft_reset_req = s;
        rst_n          = r;
        @(posedge refclk);
        model_edge(l, s, r);
        #1;
        checkOutput("step");
    endtask

    initial begin
        int n;
        tests          = 0;
        fails          = 0;
        m_phase        = M_RST;
        m_age          = 0;
        m_retries      = 0;
        m_losses       = 0;
        sync_pipe      = {1'b0, 1'b0};
        rst_n          = 1'b0;
        pll_locked     = 1'b0;
        soft_reset_req = 1'b0;

        // Reset; the last low-rst_n edge is edge 0.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        check("rst.state", 8'(state), 8'd0);
        check("rst.pll_rst", 8'(pll_rst), 8'd1);
        check("rst.spw_rst_n", 8'(spw_rst_n), 8'd0);
        check("rst.ready", 8'(ready), 8'd0);
        check("rst.fail", 8'(fail), 8'd0);
        check("rst.loss", lock_loss_cnt, 8'd0);

        // Case 1: pll_rst high through edge 3, low from edge 4; lock raised after edge 10.
        for (int e = 1; e <= 10; e++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            if (e == 3) check("t1.pll_rst_e3", 8'(pll_rst), 8'd1);
            if (e == 4) check("t1.pll_rst_e4", 8'(pll_rst), 8'd0);
        end
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            n++;
        end while (!spw_rst_n && n < 40);
        check("t1.latency", 8'(n), 8'd11);
        check("t1.state", 8'(state), 8'd3);
        check("t1.ready", 8'(ready), 8'd1);

        // Case 4: lock loss in RUN is seen after two sync stages plus the decision edge.
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            n++;
        end while (spw_rst_n && n < 10);
        check("t4.drop_latency", 8'(n), 8'd3);
        check("t4.pll_rst", 8'(pll_rst), 8'd1);
        check("t4.loss", lock_loss_cnt, 8'd1);
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            n++;
        end while (!ready && n < 60);
        check("t4.relock", 8'(ready), 8'd1);

        // Case 2: one-cycle lock glitch during STABLE.
        applyStimulus(1'b1, 1'b1, 1'b1);
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            n++;
        end while (state != 3'd2 && n < 30);
        check("t2.reach_stable", 8'(state), 8'd2);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        check("t2.back_wait", 8'(state), 8'd1);
        check("t2.ready", 8'(ready), 8'd0);
        check("t2.loss", lock_loss_cnt, 8'd1);
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            n++;
        end while (!ready && n < 30);
        check("t2.relock_cycles", 8'(n), 8'd9);

        // Case 3: no lock ever; retry once, then FAIL.
        applyStimulus(1'b0, 1'b1, 1'b1);
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            n++;
        end while (state != 3'd1 && n < 10);
        check("t3.reach_wait", 8'(state), 8'd1);
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            n++;
        end while (state == 3'd1 && n < 40);
        check("t3.timeout_cycles", 8'(n), 8'd20);
        check("t3.repulse", 8'(pll_rst), 8'd1);
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            n++;
        end while (!fail && n < 40);
        check("t3.fail", 8'(fail), 8'd1);
        check("t3.state", 8'(state), 8'd4);
        check("t3.pll_rst", 8'(pll_rst), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        check("t3.fail_held", 8'(fail), 8'd1);

        // Case 5: soft reset from FAIL, then soft reset racing a lock loss in RUN.
        applyStimulus(1'b0, 1'b1, 1'b1);
        check("t5.fail_clear", 8'(fail), 8'd0);
        check("t5.state", 8'(state), 8'd0);
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            n++;
        end while (!ready && n < 60);
        check("t5.run", 8'(ready), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        check("t5.race_state", 8'(state), 8'd0);
        check("t5.race_loss", lock_loss_cnt, 8'd1);

        // Random lock traffic with occasional soft and hard resets.
        for (int seg = 0; seg < 150; seg++) begin
            int hi_len;
            int lo_len;
            hi_len = int'($urandom_range(1, 30));
            lo_len = int'($urandom_range(1, 6));
            for (int c = 0; c < hi_len; c++)
                applyStimulus(1'b1, ($urandom_range(0, 49) == 0), ($urandom_range(0, 299) != 0));
            for (int c = 0; c < lo_len; c++)
                applyStimulus(1'b0, ($urandom_range(0, 49) == 0), 1'b1);
        end

        // Case 6: drive enough lock losses to saturate the loss counter.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 260; k++) begin
            n = 0;
            do begin
                applyStimulus(1'b1, 1'b0, 1'b1);
                n++;
            end while (!ready && n < 60);
            if (!ready) check("t6.lock_timeout", 8'(ready), 8'd1);
            n = 0;
            do begin
                applyStimulus(1'b0, 1'b0, 1'b1);
                n++;
            end while (ready && n < 10);
            if (ready) check("t6.loss_timeout", 8'(ready), 8'd0);
        end
        check("t6.saturated", lock_loss_cnt, 8'd255);
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            n++;
        end while (state != 3'd2 && n < 30);
        check("t6.reach_stable", 8'(state), 8'd2);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        check("t6.rst_state", 8'(state), 8'd0);
        check("t6.rst_pll_rst", 8'(pll_rst), 8'd1);
        check("t6.rst_spw_rst_n", 8'(spw_rst_n), 8'd0);
        check("t6.rst_ready", 8'(ready), 8'd0);
        check("t6.rst_fail", 8'(fail), 8'd0);
        check("t6.rst_loss", lock_loss_cnt, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
